battle_turn_ctrl: RTL and testbench

//  Turn sequencer for the battle screen.
//  - Alternates dodge phase (state_game=0: bee vs bullets) and attack phase (state_game=1: pangya tab).
//  - Latches bee/bullet pixel overlaps once per dodge phase and owns player and monster HP.
//  - Declares game over.
//  - Drives the renderer mux, the bullet sprites' isCollision inputs and both HP bars.

---
 rtl/battle_turn_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_battle_turn_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/battle_turn_ctrl.sv
// Battle-screen turn sequencer: dodge/attack phases, bullet hit latching, HP ownership, game over.
// Optional post-hit invulnerability window is compiled in with `define BATTLE_INVULN_EN.
module battle_turn_ctrl #(
    parameter int DODGE_FRAMES   = 600,
    parameter int ATTACK_TIMEOUT = 300,
    parameter int PLAYER_HP_MAX  = 100,
    parameter int MONSTER_HP_MAX = 100,
    parameter int BULLET_DMG     = 10
`ifdef BATTLE_INVULN_EN
    ,
    parameter int INVULN_FRAMES  = 30
`endif
) (
    input  logic       Pclk,
    input  logic       RESET,
    input  logic       frame_tick,
    input  logic       bee_on,
    input  logic       bullet1_on,
    input  logic       bullet2_on,
    input  logic       attack,
    input  logic [6:0] attack_damage,
    output logic       state_game,
    output logic       hit_b1,
    output logic       hit_b2,
    output logic [6:0] player_hp,
    output logic [6:0] monster_hp,
    output logic [9:0] frames_left,
    output logic       game_over,
    output logic       player_won
);

    typedef enum logic [1:0] {
        ST_DODGE  = 2'd0,
        ST_ATTACK = 2'd1,
        ST_OVER   = 2'd2
    } state_e;

    localparam logic [9:0] DODGE_LOAD   = 10'(DODGE_FRAMES);
    localparam logic [9:0] ATTACK_LOAD  = 10'(ATTACK_TIMEOUT);
    localparam logic [6:0] PLAYER_INIT  = 7'(PLAYER_HP_MAX);
    localparam logic [6:0] MONSTER_INIT = 7'(MONSTER_HP_MAX);
    localparam logic [7:0] DMG_ONE      = 8'(BULLET_DMG);
    localparam logic [7:0] DMG_TWO      = 8'(2 * BULLET_DMG);

    // Subtraction through an 8-bit intermediate, clamped at zero so HP never wraps.
    function automatic logic [6:0] sat_sub(input logic [6:0] a, input logic [7:0] b);
        sat_sub = (b > {1'b0, a}) ? 7'd0 : 7'({1'b0, a} - b);
    endfunction

    state_e     state_q;
    logic       state_game_q;
    logic       hit_b1_q;
    logic       hit_b2_q;
    logic [6:0] player_hp_q;
    logic [6:0] monster_hp_q;
    logic [9:0] frames_left_q;
    logic       game_over_q;
    logic       player_won_q;

    logic       overlap_ok_d;
    logic       hit1_d;
    logic       hit2_d;
    logic [7:0] hit_dmg_d;
    logic [6:0] player_hp_d;
    logic [6:0] monster_hp_d;
    logic       phase_end_d;

`ifdef BATTLE_INVULN_EN
    localparam int            IW       = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES + 1) : 1;
    localparam logic [IW-1:0] INV_LOAD = IW'(INVULN_FRAMES);

    logic [IW-1:0] invuln_q;

    assign overlap_ok_d = (invuln_q == {IW{1'b0}});

    // Invulnerability counter: loads on a counted hit, runs down on frames, cleared outside dodge.
    always_ff @(posedge Pclk) begin
        if (RESET) begin
            invuln_q <= {IW{1'b0}};
        end else if (state_q == ST_DODGE) begin
            if (phase_end_d && (player_hp_d != 7'd0)) begin
                invuln_q <= {IW{1'b0}};
            end else if (hit1_d || hit2_d) begin
                invuln_q <= INV_LOAD;
            end else if (frame_tick && !overlap_ok_d) begin
                invuln_q <= invuln_q - {{(IW-1){1'b0}}, 1'b1};
            end else begin
                invuln_q <= invuln_q;
            end
        end else begin
            invuln_q <= {IW{1'b0}};
        end
    end
`else
    assign overlap_ok_d = 1'b1;
`endif

    // New collisions, damage and saturated HP candidates for this cycle.
    always_comb begin
        hit1_d      = bee_on & bullet1_on & ~hit_b1_q & overlap_ok_d;
        hit2_d      = bee_on & bullet2_on & ~hit_b2_q & overlap_ok_d;
        phase_end_d = frame_tick & (frames_left_q == 10'd1);
        case ({hit1_d, hit2_d})
            2'b11:   hit_dmg_d = DMG_TWO;
            2'b10,
            2'b01:   hit_dmg_d = DMG_ONE;
            default: hit_dmg_d = 8'd0;
        endcase
        player_hp_d  = sat_sub(player_hp_q, hit_dmg_d);
        monster_hp_d = sat_sub(monster_hp_q, {1'b0, attack_damage});
    end

    // Turn FSM with all outputs held in registers.
    always_ff @(posedge Pclk) begin
        if (RESET) begin
            state_q       <= ST_DODGE;
            state_game_q  <= 1'b0;
            hit_b1_q      <= 1'b0;
            hit_b2_q      <= 1'b0;
            player_hp_q   <= PLAYER_INIT;
            monster_hp_q  <= MONSTER_INIT;
            frames_left_q <= DODGE_LOAD;
            game_over_q   <= 1'b0;
            player_won_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_DODGE: begin
                    hit_b1_q    <= hit_b1_q | hit1_d;
                    hit_b2_q    <= hit_b2_q | hit2_d;
                    player_hp_q <= player_hp_d;
                    // Death outranks a phase end landing on the same cycle.
                    if (player_hp_d == 7'd0) begin
                        state_q       <= ST_OVER;
                        state_game_q  <= 1'b1;
                        frames_left_q <= 10'd0;
                        game_over_q   <= 1'b1;
                        player_won_q  <= 1'b0;
                    end else if (phase_end_d) begin
                        state_q       <= ST_ATTACK;
                        state_game_q  <= 1'b1;
                        frames_left_q <= ATTACK_LOAD;
                    end else if (frame_tick) begin
                        frames_left_q <= frames_left_q - 10'd1;
                    end else begin
                        frames_left_q <= frames_left_q;
                    end
                end
                ST_ATTACK: begin
                    if (attack || phase_end_d) begin
                        if (attack) begin
                            monster_hp_q <= monster_hp_d;
                        end else begin
                            monster_hp_q <= monster_hp_q;
                        end
                        if (attack && (monster_hp_d == 7'd0)) begin
                            state_q       <= ST_OVER;
                            state_game_q  <= 1'b1;
                            frames_left_q <= 10'd0;
                            game_over_q   <= 1'b1;
                            player_won_q  <= 1'b1;
                        end else begin
                            state_q       <= ST_DODGE;
                            state_game_q  <= 1'b0;
                            hit_b1_q      <= 1'b0;
                            hit_b2_q      <= 1'b0;
                            frames_left_q <= DODGE_LOAD;
                        end
                    end else if (frame_tick) begin
                        frames_left_q <= frames_left_q - 10'd1;
                    end else begin
                        frames_left_q <= frames_left_q;
                    end
                end
                ST_OVER: begin
                    state_game_q  <= 1'b1;
                    frames_left_q <= 10'd0;
                    game_over_q   <= 1'b1;
                end
                default: begin
                    state_q      <= ST_DODGE;
                    state_game_q <= 1'b0;
                end
            endcase
        end
    end

    assign state_game  = state_game_q;
    assign hit_b1      = hit_b1_q;
    assign hit_b2      = hit_b2_q;
    assign player_hp   = player_hp_q;
    assign monster_hp  = monster_hp_q;
    assign frames_left = frames_left_q;
    assign game_over   = game_over_q;
    assign player_won  = player_won_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Randomized bench for battle_turn_ctrl: an integer-level game model predicts every cycle's outputs
// into a queue that an independent monitor drains and compares after each clock edge.
module tb_battle_turn_ctrl;

    localparam int DF     = 4;
    localparam int AT     = 3;
    localparam int PMAX   = 95;
    localparam int MMAX   = 100;
    localparam int BD     = 10;
    localparam int INV    = 2;
    localparam int CYCLES = 20000;
`ifdef BATTLE_INVULN_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    logic       Pclk = 1'b0;
    logic       RESET = 1'b1;
    logic       frame_tick = 1'b0;
    logic       bee_on = 1'b0;
    logic       bullet1_on = 1'b0;
    logic       bullet2_on = 1'b0;
    logic       attack = 1'b0;
    logic [6:0] attack_damage = 7'd0;
    logic       state_game, hit_b1, hit_b2, game_over, player_won;
    logic [6:0] player_hp, monster_hp;
    logic [9:0] frames_left;

    battle_turn_ctrl #(
        .DODGE_FRAMES   (DF),
        .ATTACK_TIMEOUT (AT),
        .PLAYER_HP_MAX  (PMAX),
        .MONSTER_HP_MAX (MMAX),
        .BULLET_DMG     (BD)
`ifdef BATTLE_INVULN_EN
        ,
        .INVULN_FRAMES  (INV)
`endif
    ) dut (
        .Pclk          (Pclk),
        .RESET         (RESET),
        .frame_tick    (frame_tick),
        .bee_on        (bee_on),
        .bullet1_on    (bullet1_on),
        .bullet2_on    (bullet2_on),
        .attack        (attack),
        .attack_damage (attack_damage),
        .state_game    (state_game),
        .hit_b1        (hit_b1),
        .hit_b2        (hit_b2),
        .player_hp     (player_hp),
        .monster_hp    (monster_hp),
        .frames_left   (frames_left),
        .game_over     (game_over),
        .player_won    (player_won)
    );

    always #20 Pclk = ~Pclk;

    typedef struct packed {
        logic       sg;
        logic       h1;
        logic       h2;
        logic [6:0] php;
        logic [6:0] mhp;
        logic [9:0] left;
        logic       go;
        logic       won;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_prints = 0;

    // Game model: phase 0 = dodge, 1 = attack, 2 = over.
    int m_phase, m_php, m_mhp, m_left, m_inv;
    bit m_h1, m_h2, m_over, m_won;

    task automatic model_step(input bit rst, input bit tick, input bit bee, input bit b1,
                              input bit b2, input bit atk, input int dmg);
        bit n1, n2, done;
        if (rst) begin
            m_phase = 0; m_php = PMAX; m_mhp = MMAX; m_left = DF; m_inv = 0;
            m_h1 = 1'b0; m_h2 = 1'b0; m_over = 1'b0; m_won = 1'b0;
        end else if (m_phase == 0) begin
            n1 = bee && b1 && !m_h1 && (m_inv == 0);
            n2 = bee && b2 && !m_h2 && (m_inv == 0);
            m_php = m_php - BD * (int'(n1) + int'(n2));
            if (m_php < 0) m_php = 0;
            m_h1 = m_h1 | n1;
            m_h2 = m_h2 | n2;
            if (m_php == 0) begin
                m_phase = 2; m_over = 1'b1; m_won = 1'b0; m_left = 0;
            end else if (tick && m_left == 1) begin
                m_phase = 1; m_left = AT; m_inv = 0;
            end else begin
                if (INV_ON && (n1 || n2)) m_inv = INV;
                else if (tick && m_inv > 0) m_inv = m_inv - 1;
                if (tick) m_left = m_left - 1;
            end
        end else if (m_phase == 1) begin
            done = 1'b0;
            if (atk) begin
                m_mhp = m_mhp - dmg;
                if (m_mhp < 0) m_mhp = 0;
                done = 1'b1;
            end else if (tick) begin
                if (m_left == 1) done = 1'b1;
                else m_left = m_left - 1;
            end
            if (done) begin
                if (m_mhp == 0) begin
                    m_phase = 2; m_over = 1'b1; m_won = 1'b1; m_left = 0;
                end else begin
                    m_phase = 0; m_h1 = 1'b0; m_h2 = 1'b0; m_left = DF;
                end
            end
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.sg   = (m_phase != 0);
        s.h1   = m_h1;
        s.h2   = m_h2;
        s.php  = 7'(m_php);
        s.mhp  = 7'(m_mhp);
        s.left = 10'(m_left);
        s.go   = m_over;
        s.won  = m_won;
        return s;
    endfunction

    // Monitor: every cycle the DUT presents a new output set; compare it with the oldest prediction.
    initial begin
        forever begin
            @(posedge Pclk);
            #1;
            if (exp_q.size() > 0) begin
                snap_t e, a;
                e = exp_q.pop_front();
                a = {state_game, hit_b1, hit_b2, player_hp, monster_hp, frames_left, game_over, player_won};
                n_checks++;
                if (a === e) begin
                    n_pass++;
                end else if (n_prints < 25) begin
                    n_prints++;
                    $display("FAIL outputs @%0t got sg=%0b h1=%0b h2=%0b php=%0d mhp=%0d left=%0d go=%0b won=%0b required sg=%0b h1=%0b h2=%0b php=%0d mhp=%0d left=%0d go=%0b won=%0b",
                             $time, a.sg, a.h1, a.h2, a.php, a.mhp, a.left, a.go, a.won,
                             e.sg, e.h1, e.h2, e.php, e.mhp, e.left, e.go, e.won);
                end
            end
        end
    end

    // Driver: randomized inputs shaped by the model phase to reach the interesting corners.
    initial begin
        bit rst, tick, bee, b1, b2, atk;
        int dmg, burst;
        burst = 0;
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge Pclk);
            rst  = (cyc < 2) || ($urandom_range(0, 799) == 0) || (m_over && $urandom_range(0, 15) == 0);
            tick = ($urandom_range(0, 7) == 0);
            bee  = ($urandom_range(0, 1) == 1);
            b1   = ($urandom_range(0, 15) == 0);
            b2   = ($urandom_range(0, 15) == 0);
            if (burst > 0) begin
                bee = 1'b1; b1 = 1'b1; burst--;
            end else if ($urandom_range(0, 299) == 0) begin
                burst = 50;
            end
            if ($urandom_range(0, 40) == 0) begin
                bee = 1'b1; b1 = 1'b1; b2 = 1'b1;
            end
            atk = ($urandom_range(0, 39) == 0);
            if (m_phase == 1 && m_left == 1 && tick && $urandom_range(0, 2) == 0) atk = 1'b1;
            dmg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 30));
            RESET         = rst;
            frame_tick    = tick;
            bee_on        = bee;
            bullet1_on    = b1;
            bullet2_on    = b2;
            attack        = atk;
            attack_damage = 7'(dmg);
            model_step(rst, tick, bee, b1, b2, atk, dmg);
            exp_q.push_back(model_snap());
        end
        @(negedge Pclk);
        RESET = 1'b0; frame_tick = 1'b0; bee_on = 1'b0; bullet1_on = 1'b0;
        bullet2_on = 1'b0; attack = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Pclk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
